// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer: one input channel steered by sel into
// four independently back-pressured single-entry output channels, with counters.
module demux4_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] dlv_cnt0,
    output logic [CNT_W-1:0] dlv_cnt1,
    output logic [CNT_W-1:0] dlv_cnt2,
    output logic [CNT_W-1:0] dlv_cnt3,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [3:0]       free;
    logic [3:0]       drain;
    logic [3:0]       load;
    logic             accept;
    logic [WIDTH-1:0] data_q [4];
    logic [CNT_W-1:0] dlv_q  [4];
    logic [CNT_W-1:0] drop_q;

    // A channel is free when empty or being drained this same cycle.
    assign free     = ~out_valid | out_ready;
    assign drain    = out_valid & out_ready;
    assign in_ready = !en || free[sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = 4'b0000;
        if (accept && en) begin
            load[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                dlv_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // Refill wins over drain so a same-cycle drain+refill stays valid.
                if (load[k]) begin
                    out_valid[k] <= 1'b1;
                    data_q[k]    <= in_data;
                end else if (drain[k]) begin
                    out_valid[k] <= 1'b0;
                end
                if (drain[k]) begin
                    dlv_q[k] <= dlv_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (accept && !en && (drop_q != {CNT_W{1'b1}})) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign dlv_cnt0  = dlv_q[0];
    assign dlv_cnt1  = dlv_q[1];
    assign dlv_cnt2  = dlv_q[2];
    assign dlv_cnt3  = dlv_q[3];
    assign drop_cnt  = drop_q;

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer: the distributing counterpart of the team's 4:1 selection mux. It accepts one WIDTH-bit beat per handshake on a single input channel and steers it, by a 2-bit select, into one of four independently back-pressured output channels. Each output channel has one holding register. Per-channel delivery counters and a drop counter are provided for scoreboard cross-checks in the UVM environment.

## Interface
- WIDTH, 4, data width of every channel
- CNT_W, 8, width of the delivery and drop counters
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  routing enable; when low, input beats are discarded
- sel  in  2  destination of the current input beat (0..3)
- in_data  in  WIDTH  input beat
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted when in_valid && in_ready
- out_data0..out_data3  out  WIDTH each  holding-register contents
- out_valid  out  4  bit k: channel k holds a beat
- out_ready  in  4  bit k: consumer takes channel k's beat this cycle
- dlv_cnt0..dlv_cnt3  out  CNT_W each  beats delivered (consumed) per channel, wrapping
- drop_cnt  out  CNT_W  beats discarded while en low, saturating

## Operation
- Channel k is drained on a cycle when out_valid[k] && out_ready[k].
- Channel k is free on a cycle when !out_valid[k] || out_ready[k], which includes same-cycle drain and refill.
- in_ready = !en || free[sel]. It is combinational from en, sel, out_valid and out_ready, with no dependence on in_valid.
- Accept with en=1: out_data{sel} <= in_data and out_valid[sel] <= 1. No other channel's register changes.
- Accept with en=0: the beat is discarded, no channel changes, and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1.
- Drain of channel k with no refill of k on the same cycle: out_valid[k] <= 0. out_data{k} holds its last value; it is not cleared.
- Drain of channel k on any cycle: dlv_cnt{k} increments, wrapping modulo 2^CNT_W.
- Channels are fully independent. A stalled channel blocks the input only while sel points at it. A beat for another channel is accepted the same cycle.
- sel and en are sampled only on cycles where in_valid && in_ready. Changing them while in_valid is held and in_ready is low is allowed; the beat routes per the values on the accepting cycle.
- Ordering within one channel is preserved because each channel has depth 1.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid = 4'b0000 and all out_data* = 0.
  - All dlv_cnt* = 0 and drop_cnt = 0.
  - in_ready follows its equation: 1 if en=0, or if en=1 (all channels are empty after reset).
- Reset asserted mid-transfer: held beats are lost and counters clear immediately. The first accept after rst_n rises is legal on the first rising edge.
- Latency: a beat accepted at edge N is visible on out_data{sel} with out_valid set after edge N. That is one cycle of latency.
- Throughput: one beat per cycle per channel while its consumer holds out_ready high.
- Output stability: out_data{k} is stable while out_valid[k] && !out_ready[k].
- Counters update on the same edge as the event they count.

## Test plan
- Reset then basic routing: en=1, drive beats 0x1,0x2,0x3,0x4 with sel=0,1,2,3 and all out_ready=1 -> each appears on its own channel one cycle later, and all dlv_cnt* = 1.
- Back-pressure and bypass:
  - Stall out_ready[2]=0 and send 0xA then 0xB to sel=2 -> 0xA is held, and in_ready drops while sel=2.
  - Meanwhile a sel=1 beat 0x5 is accepted the same cycle.
  - Raise out_ready[2] -> 0xB is accepted that cycle and appears next cycle. dlv_cnt2 = 2 after both drain.
- Disable/drop: en=0 with 300 valid beats -> in_ready=1 throughout, out_valid stays 0, and drop_cnt saturates at 255.
- Counter wrap: 257 beats to sel=3 with out_ready[3]=1 -> dlv_cnt3 = 1.
- Async reset mid-stream: assert rst_n low between edges while channels 0 and 2 are held -> out_valid = 0 and counters = 0 immediately, without waiting for a clock edge. Next accept of 0xC on sel=0 appears one cycle later.
- Randomized sel/en/out_ready for 10k cycles against the UVM reference model -> zero per-channel order or data mismatches, and counters match the model.
